// File: rtl/ysyx_22050612_lsu.sv
// Load/store unit: aligns byte/half/word/double accesses onto an NB-byte memory bus,
// splitting an access that straddles a bus word into two beats.
module ysyx_22050612_lsu #(
  parameter int DW = 64,
  parameter int AW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_wen,
  output logic [AW-1:0]   mem_req_addr,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_resp_rdata
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);
  localparam logic [AW-1:0] BEAT_STEP = AW'(NB);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic            rq_wen_q, rq_wen_d;
  logic [1:0]      rq_size_q, rq_size_d;
  logic            rq_uns_q, rq_uns_d;
  logic [AW-1:0]   rq_addr_q, rq_addr_d;
  logic [DW-1:0]   rq_wdata_q, rq_wdata_d;
  logic [DW-1:0]   beat0_q, beat0_d;
  logic [DW-1:0]   beat1_q, beat1_d;

  logic            ready_q, ready_d;
  logic            mreq_valid_q, mreq_valid_d;
  logic            mreq_wen_q, mreq_wen_d;
  logic [AW-1:0]   mreq_addr_q, mreq_addr_d;
  logic [DW-1:0]   mreq_wdata_q, mreq_wdata_d;
  logic [NB-1:0]   mreq_wmask_q, mreq_wmask_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [2*NB-1:0] mask_wide;
  logic [2*DW-1:0] data_wide;
  logic            beat_hi;

  function automatic logic [3:0] byte_len(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  function automatic logic is_illegal(input logic [1:0] size);
    return (DW == 32) && (size == 2'd3);
  endfunction

  function automatic logic is_split(input logic [OW-1:0] off, input logic [1:0] size);
    logic [4:0] last;
    last = 5'(off) + 5'(byte_len(size));
    return last > 5'(NB);
  endfunction

  function automatic logic [2*NB-1:0] store_mask(input logic [1:0] size, input logic [OW-1:0] off);
    return (~({(2*NB){1'b1}} << byte_len(size))) << off;
  endfunction

  function automatic logic [2*DW-1:0] store_data(input logic [DW-1:0] wdata, input logic [OW-1:0] off);
    return {{DW{1'b0}}, wdata} << {off, 3'b000};
  endfunction

  // keep = low 8*len bits; keep ^ (keep >> 1) isolates the sign bit of the loaded value
  function automatic logic [DW-1:0] load_ext(input logic [2*DW-1:0] cat, input logic [OW-1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [DW-1:0] raw;
    logic [DW-1:0] keep;
    logic [6:0]    nbits;
    logic          sign;
    raw   = DW'(cat >> {off, 3'b000});
    nbits = 7'd8 << size;
    keep  = ~({DW{1'b1}} << nbits);
    sign  = |(raw & (keep ^ (keep >> 1)));
    return (raw & keep) | ((!uns && sign) ? ~keep : {DW{1'b0}});
  endfunction

  // Next-state and request/beat capture
  always_comb begin
    state_d    = state_q;
    rq_wen_d   = rq_wen_q;
    rq_size_d  = rq_size_q;
    rq_uns_d   = rq_uns_q;
    rq_addr_d  = rq_addr_q;
    rq_wdata_d = rq_wdata_q;
    beat0_d    = beat0_q;
    beat1_d    = beat1_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rq_wen_d   = req_wen;
          rq_size_d  = req_size;
          rq_uns_d   = req_unsigned;
          rq_addr_d  = req_addr;
          rq_wdata_d = req_wdata;
          state_d    = is_illegal(req_size) ? DONE : REQ0;
        end else begin
          state_d = IDLE;
        end
      end
      REQ0: state_d = mem_req_ready ? WAIT0 : REQ0;
      WAIT0: begin
        if (mem_resp_valid) begin
          beat0_d = mem_resp_rdata;
          state_d = is_split(rq_addr_q[OW-1:0], rq_size_q) ? REQ1 : DONE;
        end else begin
          state_d = WAIT0;
        end
      end
      REQ1: state_d = mem_req_ready ? WAIT1 : REQ1;
      WAIT1: begin
        if (mem_resp_valid) begin
          beat1_d = mem_resp_rdata;
          state_d = DONE;
        end else begin
          state_d = WAIT1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next state so every port comes straight from a flop
  always_comb begin
    mask_wide    = store_mask(rq_size_d, rq_addr_d[OW-1:0]);
    data_wide    = store_data(rq_wdata_d, rq_addr_d[OW-1:0]);
    beat_hi      = (state_d == REQ1);
    ready_d      = (state_d == IDLE);
    mreq_valid_d = (state_d == REQ0) || (state_d == REQ1);
    mreq_wen_d   = mreq_valid_d && rq_wen_d;
    mreq_addr_d  = {AW{1'b0}};
    mreq_wmask_d = {NB{1'b0}};
    mreq_wdata_d = {DW{1'b0}};
    resp_rdata_d = {DW{1'b0}};
    if (mreq_valid_d) begin
      mreq_addr_d = {rq_addr_d[AW-1:OW], {OW{1'b0}}} + (beat_hi ? BEAT_STEP : {AW{1'b0}});
    end else begin
      mreq_addr_d = {AW{1'b0}};
    end
    if (mreq_wen_d) begin
      mreq_wmask_d = beat_hi ? mask_wide[2*NB-1:NB] : mask_wide[NB-1:0];
      mreq_wdata_d = beat_hi ? data_wide[2*DW-1:DW] : data_wide[DW-1:0];
    end else begin
      mreq_wmask_d = {NB{1'b0}};
      mreq_wdata_d = {DW{1'b0}};
    end
    resp_valid_d = (state_d == DONE);
    resp_err_d   = resp_valid_d && is_illegal(rq_size_d);
    if (resp_valid_d && !resp_err_d && !rq_wen_d) begin
      resp_rdata_d = load_ext({beat1_d, beat0_d}, rq_addr_d[OW-1:0], rq_size_d, rq_uns_d);
    end else begin
      resp_rdata_d = {DW{1'b0}};
    end
  end

  // State, request fields, beats and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rq_wen_q     <= 1'b0;
      rq_size_q    <= 2'd0;
      rq_uns_q     <= 1'b0;
      rq_addr_q    <= {AW{1'b0}};
      rq_wdata_q   <= {DW{1'b0}};
      beat0_q      <= {DW{1'b0}};
      beat1_q      <= {DW{1'b0}};
      ready_q      <= 1'b1;
      mreq_valid_q <= 1'b0;
      mreq_wen_q   <= 1'b0;
      mreq_addr_q  <= {AW{1'b0}};
      mreq_wdata_q <= {DW{1'b0}};
      mreq_wmask_q <= {NB{1'b0}};
      resp_valid_q <= 1'b0;
      resp_rdata_q <= {DW{1'b0}};
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rq_wen_q     <= rq_wen_d;
      rq_size_q    <= rq_size_d;
      rq_uns_q     <= rq_uns_d;
      rq_addr_q    <= rq_addr_d;
      rq_wdata_q   <= rq_wdata_d;
      beat0_q      <= beat0_d;
      beat1_q      <= beat1_d;
      ready_q      <= ready_d;
      mreq_valid_q <= mreq_valid_d;
      mreq_wen_q   <= mreq_wen_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_wdata_q <= mreq_wdata_d;
      mreq_wmask_q <= mreq_wmask_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready     = ready_q;
  assign mem_req_valid = mreq_valid_q;
  assign mem_req_wen   = mreq_wen_q;
  assign mem_req_addr  = mreq_addr_q;
  assign mem_req_wdata = mreq_wdata_q;
  assign mem_req_wmask = mreq_wmask_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Bench for the LSU: byte-addressed memory model and reference, directed cases plus random traffic.
module tb_ysyx_22050612_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  logic        req_valid_32, req_ready_32, req_wen_32, req_unsigned_32;
  logic [1:0]  req_size_32;
  logic [31:0] req_addr_32, req_wdata_32;
  logic        resp_valid_32, resp_err_32;
  logic [31:0] resp_rdata_32;
  logic        mem_req_valid_32, mem_req_ready_32, mem_req_wen_32;
  logic [31:0] mem_req_addr_32, mem_req_wdata_32;
  logic [3:0]  mem_req_wmask_32;
  logic        mem_resp_valid_32;
  logic [31:0] mem_resp_rdata_32;

  always #5 clk = ~clk;

  ysyx_22050612_lsu #(.DW(64), .AW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  ysyx_22050612_lsu #(.DW(32), .AW(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_32), .req_ready(req_ready_32), .req_wen(req_wen_32), .req_size(req_size_32),
    .req_unsigned(req_unsigned_32), .req_addr(req_addr_32), .req_wdata(req_wdata_32),
    .resp_valid(resp_valid_32), .resp_rdata(resp_rdata_32), .resp_err(resp_err_32),
    .mem_req_valid(mem_req_valid_32), .mem_req_ready(mem_req_ready_32), .mem_req_wen(mem_req_wen_32),
    .mem_req_addr(mem_req_addr_32), .mem_req_wdata(mem_req_wdata_32), .mem_req_wmask(mem_req_wmask_32),
    .mem_resp_valid(mem_resp_valid_32), .mem_resp_rdata(mem_resp_rdata_32)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0] mem     [logic [63:0]];
  logic [7:0] ref_mem [logic [63:0]];

  logic [63:0] b_addr  [2];
  logic [63:0] b_wdata [2];
  logic [7:0]  b_mask  [2];
  logic        b_wen   [2];
  int          nb_seen, lat_seen, pulses;
  logic [63:0] r_data;
  logic        r_err;

  function automatic logic [7:0] init_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [63:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [63:0] a, input logic [7:0] b);
    mem[a] = b;
    ref_mem[a] = b;
  endtask

  // Drive one request and act as the memory until one cycle past the response.
  task automatic txn(input logic wen, input logic [1:0] size, input logic uns,
                     input logic [63:0] addr, input logic [63:0] wdata, input int stall);
    int          stall_cnt;
    logic        pending, held;
    logic [63:0] pend_addr, h_addr, h_wdata, rd;
    logic [7:0]  h_mask;
    logic        h_wen;
    nb_seen = 0; pulses = 0; lat_seen = -1; r_data = 64'd0; r_err = 1'b0;
    stall_cnt = 0; pending = 1'b0; held = 1'b0;
    pend_addr = 64'd0; h_addr = 64'd0; h_wdata = 64'd0; h_mask = 8'd0; h_wen = 1'b0;
    @(negedge clk);
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      mem_resp_valid = 1'b0;
      mem_resp_rdata = {$urandom, $urandom};
      if (pending) begin
        for (int i = 0; i < 8; i++) rd[8*i +: 8] = mem_rd(pend_addr + 64'(i));
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rd;
        pending = 1'b0;
      end
      if (resp_valid) begin
        pulses++;
        if (lat_seen < 0) begin
          lat_seen = cyc; r_data = resp_rdata; r_err = resp_err;
        end
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (!held) begin
          held = 1'b1; h_addr = mem_req_addr; h_wdata = mem_req_wdata;
          h_mask = mem_req_wmask; h_wen = mem_req_wen;
        end else begin
          check("stall_addr", mem_req_addr, h_addr);
          check("stall_wdata", mem_req_wdata, h_wdata);
          check("stall_wmask_wen", {55'd0, mem_req_wen, mem_req_wmask}, {55'd0, h_wen, h_mask});
        end
        if (stall_cnt >= stall) begin
          mem_req_ready = 1'b1;
          if (nb_seen < 2) begin
            b_addr[nb_seen] = mem_req_addr; b_wdata[nb_seen] = mem_req_wdata;
            b_mask[nb_seen] = mem_req_wmask; b_wen[nb_seen] = mem_req_wen;
          end
          if (mem_req_wen) begin
            for (int i = 0; i < 8; i++)
              if (mem_req_wmask[i]) mem[mem_req_addr + 64'(i)] = mem_req_wdata[8*i +: 8];
          end
          pending = 1'b1; pend_addr = mem_req_addr;
          nb_seen++; held = 1'b0; stall_cnt = 0;
        end else begin
          stall_cnt++;
        end
      end
      if (lat_seen >= 0 && cyc >= lat_seen + 1) break;
      req_valid = (lat_seen < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
      req_size = 2'($urandom_range(0, 3)); req_wen = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    check("resp_seen", {63'd0, lat_seen >= 0}, 64'd1);
    check("resp_pulses", 64'(pulses), 64'd1);
  endtask

  // Run a transaction and compare everything against the byte-level reference.
  task automatic txn_chk(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata, input int stall);
    int          len, nexp, nchk, j;
    logic [63:0] first, last, ba, exp_wd, keepb, ev, got;
    logic [7:0]  em;
    len   = 1 << size;
    first = addr & ~64'h7;
    last  = (addr + 64'(len) - 64'd1) & ~64'h7;
    nexp  = (first == last) ? 1 : 2;
    txn(wen, size, uns, addr, wdata, stall);
    check("beat_count", 64'(nb_seen), 64'(nexp));
    check("latency", 64'(lat_seen), 64'(1 + nexp * (2 + stall)));
    nchk = (nb_seen < nexp) ? nb_seen : nexp;
    for (int k = 0; k < nchk; k++) begin
      ba = first + 64'(8 * k);
      em = 8'd0; exp_wd = 64'd0; keepb = 64'd0;
      for (int i = 0; i < 8; i++) begin
        if (wen && ((ba + 64'(i) - addr) < 64'(len))) begin
          j = int'(ba + 64'(i) - addr);
          em[i] = 1'b1;
          keepb[8*i +: 8] = 8'hFF;
          exp_wd[8*i +: 8] = wdata[8*j +: 8];
        end
      end
      check("beat_addr", b_addr[k], ba);
      check("beat_wen", {63'd0, b_wen[k]}, {63'd0, wen});
      check("beat_wmask", {56'd0, b_mask[k]}, {56'd0, em});
      check("beat_wdata", b_wdata[k] & keepb, exp_wd);
    end
    ev = 64'd0;
    if (wen) begin
      for (int i = 0; i < len; i++) ref_mem[addr + 64'(i)] = wdata[8*i +: 8];
      got = 64'd0;
      for (int i = 0; i < len; i++) begin
        got[8*i +: 8] = mem_rd(addr + 64'(i));
        ev[8*i +: 8]  = ref_rd(addr + 64'(i));
      end
      check("store_bytes", got, ev);
      ev = 64'd0;
    end else begin
      for (int i = 0; i < len; i++) ev[8*i +: 8] = ref_rd(addr + 64'(i));
      if (!uns && len < 8 && ev[8*len-1]) ev = ev | (~64'd0 << (8*len));
    end
    check("resp_rdata", r_data, ev);
    check("resp_err", {63'd0, r_err}, 64'd0);
  endtask

  initial begin
    logic [63:0] word;
    rst_n = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'd0;
    req_valid_32 = 1'b0; req_wen_32 = 1'b0; req_size_32 = 2'd0; req_unsigned_32 = 1'b0;
    req_addr_32 = 32'd0; req_wdata_32 = 32'd0;
    mem_req_ready_32 = 1'b1; mem_resp_valid_32 = 1'b0; mem_resp_rdata_32 = 32'd0;

    @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp", {62'd0, resp_valid, resp_err}, 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_mreq", {62'd0, mem_req_valid, mem_req_wen}, 64'd0);
    check("rst_maddr", mem_req_addr, 64'd0);
    check("rst_mwdata", mem_req_wdata, 64'd0);
    check("rst_mwmask", {56'd0, mem_req_wmask}, 64'd0);
    check("rst_ready32", {63'd0, req_ready_32}, 64'd1);
    rst_n = 1'b1;

    // signed and unsigned word load from the upper half of a bus word
    word = 64'h8765432100000000;
    for (int i = 0; i < 8; i++) poke(64'h80000000 + 64'(i), word[8*i +: 8]);
    txn_chk(1'b0, 2'd2, 1'b0, 64'h80000004, 64'd0, 0);
    check("lw_signed", r_data, 64'hFFFFFFFF87654321);
    check("lw_beat_addr", b_addr[0], 64'h80000000);
    txn_chk(1'b0, 2'd2, 1'b1, 64'h80000004, 64'd0, 0);
    check("lw_unsigned", r_data, 64'h0000000087654321);

    // split halfword load
    poke(64'h80000007, 8'hAB);
    poke(64'h80000008, 8'h80);
    txn_chk(1'b0, 2'd1, 1'b0, 64'h80000007, 64'd0, 0);
    check("lh_split", r_data, 64'hFFFFFFFFFFFF80AB);

    // split halfword store
    txn_chk(1'b1, 2'd1, 1'b0, 64'h80000007, 64'h1234, 0);
    check("sh_b0_addr", b_addr[0], 64'h80000000);
    check("sh_b0_mask", {56'd0, b_mask[0]}, 64'h80);
    check("sh_b0_byte", {56'd0, b_wdata[0][63:56]}, 64'h34);
    check("sh_b1_addr", b_addr[1], 64'h80000008);
    check("sh_b1_mask", {56'd0, b_mask[1]}, 64'h01);
    check("sh_b1_byte", {56'd0, b_wdata[1][7:0]}, 64'h12);

    // byte store under four cycles of backpressure
    txn_chk(1'b1, 2'd0, 1'b0, 64'h10000003, 64'h5A, 4);
    check("sb_mask", {56'd0, b_mask[0]}, 64'h08);
    check("sb_byte", {56'd0, b_wdata[0][31:24]}, 64'h5A);

    // random mixed traffic over a small window so loads see earlier stores
    for (int n = 0; n < 40; n++) begin
      txn_chk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              64'h80000000 + 64'($urandom_range(0, 47)), {$urandom, $urandom},
              $urandom_range(0, 2));
    end

    // reset while waiting for the second beat of a split load
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 64'h80000007;
    @(negedge clk);
    req_valid = 1'b0;
    check("rw_req0", {63'd0, mem_req_valid}, 64'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h1122334455667788;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("rw_req1", {63'd0, mem_req_valid}, 64'd1);
    check("rw_req1_addr", mem_req_addr, 64'h80000008);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rw_wait1", {62'd0, mem_req_valid, resp_valid}, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rw_ready", {63'd0, req_ready}, 64'd1);
    check("rw_quiet", {62'd0, resp_valid, mem_req_valid}, 64'd0);
    mem_resp_valid = 1'b1; mem_resp_rdata = 64'hDEADBEEFDEADBEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("rw_late_resp", {62'd0, resp_valid, mem_req_valid}, 64'd0);
    check("rw_ready2", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    check("rw_late_resp2", {63'd0, resp_valid}, 64'd0);

    // doubleword request on a 32-bit bus is rejected without touching memory
    req_valid_32 = 1'b1; req_size_32 = 2'd3; req_addr_32 = 32'h80000000;
    req_wdata_32 = 32'hFFFFFFFF;
    @(negedge clk);
    req_valid_32 = 1'b0;
    check("ill_mreq", {63'd0, mem_req_valid_32}, 64'd0);
    check("ill_resp", {62'd0, resp_valid_32, resp_err_32}, 64'd3);
    check("ill_rdata", {32'd0, resp_rdata_32}, 64'd0);
    @(negedge clk);
    check("ill_once", {62'd0, resp_valid_32, mem_req_valid_32}, 64'd0);
    check("ill_ready", {63'd0, req_ready_32}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
